// File: rtl/fp_alu_pkg.sv
// Shared definitions for the fp alu arbiter: op codes, flag positions,
// default quiet-NaN patterns and the arbiter state encoding.
package fp_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV0      = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
  localparam logic [31:0] QNAN_HP = 32'h7E00_0000;

  // An aborted operation is reported as an invalid operation.
  localparam logic [4:0] ABORT_FLAGS = 5'(1 << FLAG_INVALID);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  function automatic logic [31:0] qnan_for(input logic mode_fp);
    return mode_fp ? QNAN_SP : QNAN_HP;
  endfunction

endpackage

// File: rtl/fp_alu_arbiter_if.sv
// Client-side request/response bus and ALU-side start/valid bus.
// master drives requests (or ALU commands); slave answers them.
interface fp_req_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [32*N_REQ-1:0] req_op_a;
  logic [32*N_REQ-1:0] req_op_b;
  logic [3*N_REQ-1:0] req_op_code;
  logic [N_REQ-1:0]   req_mode_fp;
  logic [2*N_REQ-1:0] req_round;
  logic               resp_valid;
  logic               resp_ready;
  logic [N_REQ-1:0]   resp_id;
  logic [31:0]        resp_result;
  logic [4:0]         resp_flags;
  logic               resp_err;

  modport master (
    output req_valid, req_op_a, req_op_b, req_op_code, req_mode_fp, req_round, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_flags, resp_err
  );
  modport slave (
    input  req_valid, req_op_a, req_op_b, req_op_code, req_mode_fp, req_round, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_flags, resp_err
  );
endinterface

interface fp_alu_if;
  logic        alu_start;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [2:0]  alu_op_code;
  logic        alu_mode_fp;
  logic [1:0]  alu_round;
  logic [31:0] alu_result;
  logic [4:0]  alu_flags;
  logic        alu_valid_out;

  modport master (
    output alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round,
    input  alu_result, alu_flags, alu_valid_out
  );
  modport slave (
    input  alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round,
    output alu_result, alu_flags, alu_valid_out
  );
endinterface

// File: rtl/fp_alu_arbiter_rr.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % N_REQ]) begin
        any                               = 1'b1;
        grant[(int'(ptr) + k) % N_REQ]    = 1'b1;
        grant_idx                         = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Shares one fp ALU between N_REQ clients: round-robin grant, operand latch,
// start/valid handshake, tagged response and a watchdog abort.
module fp_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input logic       clk,
  input logic       rst,
  fp_req_if.slave   req_bus,
  fp_alu_if.master  alu_bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TO_W-1:0] CNT_MAX = TO_W'(TIMEOUT);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] ptr, grant_idx;
  logic [N_REQ-1:0] grant, owner;
  logic [TO_W-1:0]  cnt;
  logic             any_req, take, cap_ok, cap_abort, resp_done, cnt_inc, cnt_at_max;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign cnt_at_max      = (cnt == CNT_MAX);
  assign req_bus.resp_id = owner;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Start stays high through RESP so the ALU keeps its result until consumed.
  always_comb begin
    state_next        = state;
    take              = 1'b0;
    cap_ok            = 1'b0;
    cap_abort         = 1'b0;
    resp_done         = 1'b0;
    cnt_inc           = 1'b0;
    req_bus.req_ready = '0;
    alu_bus.alu_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req && !rst) begin
          take              = 1'b1;
          req_bus.req_ready = grant;
          state_next        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_bus.alu_start = 1'b1;
        cnt_inc           = 1'b1;
        if (alu_bus.alu_valid_out) begin
          cap_ok     = 1'b1;
          state_next = ST_RESP;
        end else if (cnt_at_max) begin
          cap_abort  = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        alu_bus.alu_start = 1'b1;
        if (req_bus.resp_valid && req_bus.resp_ready) begin
          resp_done  = 1'b1;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        cnt_inc = 1'b1;
        if (!alu_bus.alu_valid_out || (req_bus.resp_err && cnt_at_max))
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr                 <= IDX_W'(N_REQ - 1);
      owner               <= '0;
      cnt                 <= '0;
      alu_bus.alu_op_a    <= '0;
      alu_bus.alu_op_b    <= '0;
      alu_bus.alu_op_code <= '0;
      alu_bus.alu_mode_fp <= 1'b0;
      alu_bus.alu_round   <= '0;
      req_bus.resp_valid  <= 1'b0;
      req_bus.resp_result <= '0;
      req_bus.resp_flags  <= '0;
      req_bus.resp_err    <= 1'b0;
    end else begin
      if (take) begin
        ptr                 <= grant_idx;
        owner               <= grant;
        alu_bus.alu_op_a    <= req_bus.req_op_a[32*int'(grant_idx) +: 32];
        alu_bus.alu_op_b    <= req_bus.req_op_b[32*int'(grant_idx) +: 32];
        alu_bus.alu_op_code <= req_bus.req_op_code[3*int'(grant_idx) +: 3];
        alu_bus.alu_mode_fp <= req_bus.req_mode_fp[grant_idx];
        alu_bus.alu_round   <= req_bus.req_round[2*int'(grant_idx) +: 2];
      end

      // Saturating watchdog, restarted for both the issue and release waits.
      if (take || resp_done)          cnt <= '0;
      else if (cnt_inc && !cnt_at_max) cnt <= cnt + TO_W'(1);

      if (cap_ok) begin
        req_bus.resp_valid  <= 1'b1;
        req_bus.resp_result <= alu_bus.alu_result;
        req_bus.resp_flags  <= alu_bus.alu_flags;
        req_bus.resp_err    <= 1'b0;
      end else if (cap_abort) begin
        req_bus.resp_valid  <= 1'b1;
        req_bus.resp_result <= qnan_for(alu_bus.alu_mode_fp);
        req_bus.resp_flags  <= ABORT_FLAGS;
        req_bus.resp_err    <= 1'b1;
      end else if (resp_done) begin
        req_bus.resp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed bench for fp_alu_arbiter with a small fixed-latency ALU model.
module tb_fp_alu_arbiter;
  import fp_alu_pkg::*;

  localparam int N_REQ    = 4;
  localparam int TIMEOUT  = 64;
  localparam int TO_W     = 7;
  localparam int ALU_LAT  = 3;
  localparam int WAIT_MAX = 300;

  logic clk = 1'b0;
  logic rst;
  logic alu_hang;
  int   alu_cnt;
  int   n_compared     = 0;
  int   n_mismatched   = 0;
  int   ready_pulses   = 0;
  int   grants_waited  = 0;

  always #5 clk = ~clk;

  fp_req_if #(.N_REQ(N_REQ)) req_if ();
  fp_alu_if alu_if ();

  fp_alu_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_bus (req_if),
    .alu_bus (alu_if)
  );

  // Hand-known results for the directed vectors; anything else returns a^b, inexact.
  function automatic logic [36:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return {5'b00000, 32'h4040_0000};
    if (op == OP_DIV && b[30:0] == 31'd0) return {5'b01000, 32'h7F80_0000};
    return {5'b00001, a ^ b};
  endfunction

  always_ff @(posedge clk) begin
    if (rst || !alu_if.alu_start) begin
      alu_cnt              <= 0;
      alu_if.alu_valid_out <= 1'b0;
      if (rst) begin
        alu_if.alu_result <= '0;
        alu_if.alu_flags  <= '0;
      end
    end else if (!alu_if.alu_valid_out && !alu_hang) begin
      if (alu_cnt == ALU_LAT - 1) begin
        alu_if.alu_valid_out <= 1'b1;
        {alu_if.alu_flags, alu_if.alu_result} <= alu_model(alu_if.alu_op_code, alu_if.alu_op_a, alu_if.alu_op_b);
      end else begin
        alu_cnt <= alu_cnt + 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic mode);
    req_if.req_op_a[32*idx +: 32]  = a;
    req_if.req_op_b[32*idx +: 32]  = b;
    req_if.req_op_code[3*idx +: 3] = op;
    req_if.req_mode_fp[idx]        = mode;
    req_if.req_round[2*idx +: 2]   = 2'b00;
    req_if.req_valid[idx]          = 1'b1;
  endtask

  task automatic reset_assert();
    @(posedge clk); #1;
    rst                = 1'b1;
    req_if.req_valid   = '0;
    req_if.resp_ready  = 1'b1;
    alu_hang           = 1'b0;
  endtask

  task automatic reset_release();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_req(input int idx);
    @(posedge clk); #1;
    req_if.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp_id);
    logic [3:0] got;
    got = '0;
    grants_waited++;
    for (int i = 0; i < WAIT_MAX && got == '0; i++) begin
      @(negedge clk);
      got = req_if.req_ready;
    end
    check_output({tag, "_grant"}, 32'(got), 32'(exp_id));
  endtask

  task automatic wait_resp(input string tag, input logic [3:0] exp_id, input logic [31:0] exp_res,
                           input logic [4:0] exp_flags, input logic exp_err);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < WAIT_MAX && !seen; i++) begin
      @(negedge clk);
      seen = req_if.resp_valid;
    end
    check_output({tag, "_resp_valid"}, 32'(seen), 32'd1);
    check_output({tag, "_resp_id"}, 32'(req_if.resp_id), 32'(exp_id));
    check_output({tag, "_resp_result"}, req_if.resp_result, exp_res);
    check_output({tag, "_resp_flags"}, 32'(req_if.resp_flags), 32'(exp_flags));
    check_output({tag, "_resp_err"}, 32'(req_if.resp_err), 32'(exp_err));
  endtask

  always @(negedge clk) begin
    if (req_if.req_ready != '0) begin
      ready_pulses++;
      check_output("ready_onehot", 32'($countones(req_if.req_ready)), 32'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int  cyc;
    logic seen;
    rst                = 1'b1;
    alu_hang           = 1'b0;
    req_if.req_valid   = '0;
    req_if.req_op_a    = '0;
    req_if.req_op_b    = '0;
    req_if.req_op_code = '0;
    req_if.req_mode_fp = '0;
    req_if.req_round   = '0;
    req_if.resp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_output("rst_req_ready", 32'(req_if.req_ready), 32'd0);
    check_output("rst_alu_start", 32'(alu_if.alu_start), 32'd0);
    check_output("rst_resp_valid", 32'(req_if.resp_valid), 32'd0);
    check_output("rst_resp_id", 32'(req_if.resp_id), 32'd0);
    check_output("rst_resp_result", req_if.resp_result, 32'd0);
    check_output("rst_resp_misc", 32'({req_if.resp_flags, req_if.resp_err}), 32'd0);
    check_output("rst_alu_ops", alu_if.alu_op_a | alu_if.alu_op_b, 32'd0);
    check_output("rst_alu_ctl", 32'({alu_if.alu_op_code, alu_if.alu_mode_fp, alu_if.alu_round}), 32'd0);

    // Single ADD; payload changed after grant must be ignored
    @(posedge clk); #1;
    apply_stimulus(0, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 1'b1);
    wait_grant("t1", 4'b0001);
    @(posedge clk); #1;
    req_if.req_valid[0]       = 1'b0;
    req_if.req_op_a[31:0]     = 32'hDEAD_BEEF;
    req_if.req_op_code[2:0]   = OP_DIV;
    @(negedge clk);
    check_output("t1_alu_start", 32'(alu_if.alu_start), 32'd1);
    check_output("t1_alu_op_a", alu_if.alu_op_a, 32'h3F80_0000);
    check_output("t1_alu_op_b", alu_if.alu_op_b, 32'h4000_0000);
    check_output("t1_alu_ctl", 32'({alu_if.alu_op_code, alu_if.alu_mode_fp}), 32'({OP_ADD, 1'b1}));
    wait_resp("t1", 4'b0001, 32'h4040_0000, 5'b00000, 1'b0);

    // All requesters held from reset: grants rotate 0,1,2,3,0
    reset_assert();
    for (int i = 0; i < N_REQ; i++)
      apply_stimulus(i, 32'h4000_0000 + i, 32'h0000_0100 << i, OP_MUL, 1'b1);
    reset_release();
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("t2_%0d", k), 4'(1 << (k % N_REQ)));
      wait_resp($sformatf("t2_%0d", k), 4'(1 << (k % N_REQ)),
                (32'h4000_0000 + 32'(k % N_REQ)) ^ (32'h0000_0100 << (k % N_REQ)), 5'b00001, 1'b0);
    end
    @(posedge clk); #1 req_if.req_valid = '0;

    // Response back-pressure with another requester waiting
    reset_assert();
    apply_stimulus(1, 32'h1111_1111, 32'h2222_2222, OP_SUB, 1'b1);
    apply_stimulus(3, 32'h3333_3333, 32'h4444_4444, OP_SUB, 1'b0);
    req_if.resp_ready = 1'b0;
    reset_release();
    wait_grant("t3a", 4'b0010);
    clear_req(1);
    wait_resp("t3a", 4'b0010, 32'h3333_3333, 5'b00001, 1'b0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_output($sformatf("t3_hold%0d_valid", s), 32'(req_if.resp_valid), 32'd1);
      check_output($sformatf("t3_hold%0d_result", s), req_if.resp_result, 32'h3333_3333);
      check_output($sformatf("t3_hold%0d_start", s), 32'(alu_if.alu_start), 32'd1);
      check_output($sformatf("t3_hold%0d_ready", s), 32'(req_if.req_ready), 32'd0);
    end
    @(posedge clk); #1 req_if.resp_ready = 1'b1;
    @(negedge clk);
    check_output("t3_last_valid", 32'(req_if.resp_valid), 32'd1);
    @(negedge clk);
    check_output("t3_consumed_valid", 32'(req_if.resp_valid), 32'd0);
    check_output("t3_consumed_start", 32'(alu_if.alu_start), 32'd0);
    wait_grant("t3b", 4'b1000);
    clear_req(3);
    wait_resp("t3b", 4'b1000, 32'h7777_7777, 5'b00001, 1'b0);

    // Divide by zero on requester 2
    reset_assert();
    apply_stimulus(2, 32'h3F80_0000, 32'h0000_0000, OP_DIV, 1'b1);
    reset_release();
    wait_grant("t4", 4'b0100);
    clear_req(2);
    wait_resp("t4", 4'b0100, 32'h7F80_0000, 5'b01000, 1'b0);

    // Hung ALU: watchdog abort in single then half mode, then a normal op
    reset_assert();
    alu_hang = 1'b1;
    apply_stimulus(1, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 1'b1);
    reset_release();
    wait_grant("t5a", 4'b0010);
    clear_req(1);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < WAIT_MAX && !seen; i++) begin
      @(negedge clk);
      if (req_if.resp_valid) seen = 1'b1;
      else if (alu_if.alu_start) cyc++;
    end
    check_output("t5a_abort_delay_ok", 32'(cyc >= TIMEOUT && cyc <= TIMEOUT + 1), 32'd1);
    check_output("t5a_resp_valid", 32'(seen), 32'd1);
    check_output("t5a_resp_result", req_if.resp_result, 32'h7FC0_0000);
    check_output("t5a_resp_flags", 32'(req_if.resp_flags), 32'h10);
    check_output("t5a_resp_err", 32'(req_if.resp_err), 32'd1);
    check_output("t5a_resp_id", 32'(req_if.resp_id), 32'h2);
    @(posedge clk); #1;
    apply_stimulus(2, 32'h3C00_0000, 32'h4000_0000, OP_ADD, 1'b0);
    wait_grant("t5b", 4'b0100);
    clear_req(2);
    wait_resp("t5b", 4'b0100, 32'h7E00_0000, 5'b10000, 1'b1);
    @(posedge clk); #1;
    alu_hang = 1'b0;
    apply_stimulus(3, 32'h0000_0005, 32'h0000_0006, OP_SUB, 1'b1);
    wait_grant("t5c", 4'b1000);
    clear_req(3);
    wait_resp("t5c", 4'b1000, 32'h0000_0003, 5'b00001, 1'b0);

    // Reset during ISSUE loses the operation and restores the pointer
    reset_assert();
    apply_stimulus(0, 32'hA000_0000, 32'h0000_000A, OP_MUL, 1'b1);
    apply_stimulus(2, 32'hB000_0000, 32'h0000_000B, OP_MUL, 1'b1);
    reset_release();
    wait_grant("t6a", 4'b0001);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("t6_rst_start", 32'(alu_if.alu_start), 32'd0);
    check_output("t6_rst_resp_valid", 32'(req_if.resp_valid), 32'd0);
    check_output("t6_rst_req_ready", 32'(req_if.req_ready), 32'd0);
    check_output("t6_rst_op_a", alu_if.alu_op_a, 32'd0);
    check_output("t6_rst_resp_id", 32'(req_if.resp_id), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    wait_grant("t6b", 4'b0001);
    clear_req(0);
    wait_resp("t6b", 4'b0001, 32'hA000_000A, 5'b00001, 1'b0);
    wait_grant("t6c", 4'b0100);
    clear_req(2);
    wait_resp("t6c", 4'b0100, 32'hB000_000B, 5'b00001, 1'b0);

    repeat (4) @(negedge clk);
    check_output("ready_pulse_count", 32'(ready_pulses), 32'(grants_waited));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
